// File: rtl/tinyodin_syn_bridge_pkg.sv
// Shared types and constants for the tinyODIN synapse OBI bridge.
// Default OBI request/response structs stand in when no obi_pkg types are supplied.
package tinyodin_syn_bridge_pkg;

    localparam int SYN_WORD_W = 32;
    localparam int SYN_BE_W   = 4;
    localparam int OBI_AW     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } syn_state_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [SYN_BE_W-1:0]   be;
        logic [OBI_AW-1:0]     addr;
        logic [SYN_WORD_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [SYN_WORD_W-1:0] rdata;
    } obi_rsp_t;

    // A write needs read-modify-write only when some but not all bytes are enabled.
    function automatic logic is_partial_be(input logic [SYN_BE_W-1:0] be);
        return (be != 4'hF) && (be != 4'h0);
    endfunction

endpackage

// File: rtl/tinyodin_be_merge.sv
// Combinational byte merge: byte i of the result comes from new_i when be_i[i] is set,
// otherwise from old_i.
module tinyodin_be_merge
    import tinyodin_syn_bridge_pkg::*;
(
    input  logic [SYN_WORD_W-1:0] old_i,
    input  logic [SYN_WORD_W-1:0] new_i,
    input  logic [SYN_BE_W-1:0]   be_i,
    output logic [SYN_WORD_W-1:0] merged_o
);

    // Per-byte select between stored and incoming data.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < SYN_BE_W; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = old_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/tinyodin_synapse_obi_bridge.sv
// OBI slave sharing the single-port synaptic SRAM with the SNN core (core has strict priority);
// partial writes become read-modify-write. Optional stall counter: TINYODIN_SYN_BRIDGE_STATS_EN.
module tinyodin_synapse_obi_bridge
    import tinyodin_syn_bridge_pkg::*;
#(
    parameter type         req_t  = obi_req_t,
    parameter type         rsp_t  = obi_rsp_t,
    parameter int unsigned SYN_AW = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  req_t                  obi_req_i,
    output rsp_t                  obi_resp_o,
    input  logic                  core_syn_cs_i,
    input  logic                  core_syn_we_i,
    input  logic [SYN_AW-1:0]     core_syn_addr_i,
    input  logic [SYN_WORD_W-1:0] core_syn_wdata_i,
    output logic [SYN_WORD_W-1:0] core_syn_rdata_o,
    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic [SYN_AW-1:0]     sram_addr_o,
    output logic [SYN_WORD_W-1:0] sram_wdata_o,
    input  logic [SYN_WORD_W-1:0] sram_rdata_i
`ifdef TINYODIN_SYN_BRIDGE_STATS_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    syn_state_e            state_q, state_d;
    logic [SYN_AW-1:0]     addr_q, addr_d;
    logic [SYN_BE_W-1:0]   be_q, be_d;
    logic [SYN_WORD_W-1:0] wdata_q, wdata_d;
    logic [SYN_WORD_W-1:0] merge_q, merge_d;
    logic                  rd_issued_q, rd_issued_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rd_pend_q, rd_pend_d;

    logic                  gnt_s;
    logic                  hazard_s;
    logic [SYN_AW-1:0]     req_addr_s;
    logic [SYN_WORD_W-1:0] merged_s;
    logic                  br_cs_s;
    logic                  br_we_s;
    logic [SYN_AW-1:0]     br_addr_s;
    logic [SYN_WORD_W-1:0] br_wdata_s;
    logic                  unused_addr_bits;

    assign req_addr_s       = obi_req_i.addr[SYN_AW+1:2];
    assign unused_addr_bits = ^{obi_req_i.addr[OBI_AW-1:SYN_AW+2], obi_req_i.addr[1:0]};
    assign gnt_s            = obi_req_i.req & (state_q == IDLE) & ~core_syn_cs_i & ~rst_i;
    assign hazard_s         = core_syn_cs_i & core_syn_we_i & (core_syn_addr_i == addr_q);
    assign core_syn_rdata_o = sram_rdata_i;

    tinyodin_be_merge u_be_merge (
        .old_i    (sram_rdata_i),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged_s)
    );

    // Transaction FSM: grant handling, RMW sequencing and bridge-side SRAM request.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        rd_issued_d = rd_issued_q;
        rvalid_d    = 1'b0;
        rd_pend_d   = 1'b0;
        br_cs_s     = 1'b0;
        br_we_s     = 1'b0;
        br_addr_s   = addr_q;
        br_wdata_s  = merge_q;
        case (state_q)
            IDLE: begin
                if (gnt_s) begin
                    if (!obi_req_i.we) begin
                        br_cs_s   = 1'b1;
                        br_addr_s = req_addr_s;
                        rvalid_d  = 1'b1;
                        rd_pend_d = 1'b1;
                    end else if (is_partial_be(obi_req_i.be)) begin
                        br_cs_s     = 1'b1;
                        br_addr_s   = req_addr_s;
                        addr_d      = req_addr_s;
                        be_d        = obi_req_i.be;
                        wdata_d     = obi_req_i.wdata;
                        rd_issued_d = 1'b1;
                        state_d     = RMW_RD;
                    end else if (obi_req_i.be == 4'hF) begin
                        br_cs_s    = 1'b1;
                        br_we_s    = 1'b1;
                        br_addr_s  = req_addr_s;
                        br_wdata_s = obi_req_i.wdata;
                        rvalid_d   = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_RD: begin
                // A core write landing while our read data is in flight makes it stale.
                if (rd_issued_q) begin
                    rd_issued_d = 1'b0;
                    if (hazard_s) begin
                        state_d = RMW_RD;
                    end else begin
                        merge_d = merged_s;
                        state_d = RMW_WR;
                    end
                end else if (!core_syn_cs_i) begin
                    br_cs_s     = 1'b1;
                    rd_issued_d = 1'b1;
                end else begin
                    rd_issued_d = 1'b0;
                end
            end
            RMW_WR: begin
                if (hazard_s) begin
                    rd_issued_d = 1'b0;
                    state_d     = RMW_RD;
                end else if (!core_syn_cs_i) begin
                    br_cs_s  = 1'b1;
                    br_we_s  = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    state_d = RMW_WR;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM port mux: the core always wins; the bridge is silenced during reset.
    always_comb begin
        if (!core_syn_cs_i && br_cs_s && !rst_i) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = br_we_s;
            sram_addr_o  = br_addr_s;
            sram_wdata_o = br_wdata_s;
        end else begin
            sram_cs_o    = core_syn_cs_i;
            sram_we_o    = core_syn_we_i;
            sram_addr_o  = core_syn_addr_i;
            sram_wdata_o = core_syn_wdata_i;
        end
    end

    // OBI response assembly; read data passes straight from the SRAM in the rvalid cycle.
    always_comb begin
        obi_resp_o        = '0;
        obi_resp_o.gnt    = gnt_s;
        obi_resp_o.rvalid = rvalid_q;
        if (rd_pend_q) begin
            obi_resp_o.rdata = sram_rdata_i;
        end else begin
            obi_resp_o.rdata = {SYN_WORD_W{1'b0}};
        end
    end

    // State and latch registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= {SYN_AW{1'b0}};
            be_q        <= {SYN_BE_W{1'b0}};
            wdata_q     <= {SYN_WORD_W{1'b0}};
            merge_q     <= {SYN_WORD_W{1'b0}};
            rd_issued_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            rd_issued_q <= rd_issued_d;
            rvalid_q    <= rvalid_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

`ifdef TINYODIN_SYN_BRIDGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles a bus request waits without a grant.
    always_comb begin
        if (obi_req_i.req && !gnt_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tinyodin_synapse_obi_bridge.sv
// Directed scoreboard bench for tinyodin_synapse_obi_bridge with a behavioural SRAM model.
// Honours TINYODIN_SYN_BRIDGE_STATS_EN for the stall counter port.
module tb_tinyodin_synapse_obi_bridge;
    import tinyodin_syn_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    obi_req_t    obi_req;
    obi_rsp_t    obi_resp;
    logic        core_cs, core_we;
    logic [12:0] core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        sram_cs, sram_we;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
`ifdef TINYODIN_SYN_BRIDGE_STATS_EN
    logic [31:0] stall_cnt;
`endif

    logic [31:0] mem [0:8191];
    logic        pl_en = 1'b0;
    logic [12:0] pl_addr = 13'd0;
    logic [31:0] pl_data = 32'd0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    tinyodin_synapse_obi_bridge #(.SYN_AW(13)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .obi_req_i        (obi_req),
        .obi_resp_o       (obi_resp),
        .core_syn_cs_i    (core_cs),
        .core_syn_we_i    (core_we),
        .core_syn_addr_i  (core_addr),
        .core_syn_wdata_i (core_wdata),
        .core_syn_rdata_o (core_rdata),
        .sram_cs_o        (sram_cs),
        .sram_we_o        (sram_we),
        .sram_addr_o      (sram_addr),
        .sram_wdata_o     (sram_wdata),
        .sram_rdata_i     (sram_rdata)
`ifdef TINYODIN_SYN_BRIDGE_STATS_EN
        ,
        .stall_cnt_o      (stall_cnt)
`endif
    );

    // Single-port SRAM model with one-cycle read latency and a backdoor preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (sram_cs) begin
            acc_cnt <= acc_cnt + 1;
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One OBI transaction: wait for grant, push expected rdata, wait for rvalid, pop and compare.
    task automatic obi_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input int exp_lat, input string tag, output int waits);
        int          lat;
        bit          done;
        logic [31:0] seen;
        logic [31:0] exp_v;
        obi_req = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
        waits = 0; done = 1'b0;
        while (!done && waits < 40) begin
            @(negedge clk);
            if (obi_resp.gnt) done = 1'b1; else waits++;
            @(posedge clk); #1;
        end
        obi_req.req = 1'b0;
        chk({tag, "_gnt"}, {31'd0, done}, 32'd1);
        if (done) exp_q.push_back(exp_rdata);
        lat = 0; done = 1'b0; seen = 32'd0;
        while (!done && lat < 40) begin
            lat++;
            @(negedge clk);
            if (obi_resp.rvalid) begin
                done = 1'b1;
                seen = obi_resp.rdata;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        if (done && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk({tag, "_rdata"}, seen, exp_v);
        end
    endtask

    int w;
    int w0;
    int a0;

    initial begin
        rst_i = 1'b1;
        obi_req = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_0040, wdata: 32'd0};
        core_cs = 1'b0; core_we = 1'b0; core_addr = 13'd0; core_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_gnt", {31'd0, obi_resp.gnt}, 32'd0);
        chk("reset_rvalid", {31'd0, obi_resp.rvalid}, 32'd0);
        chk("reset_rdata", obi_resp.rdata, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        obi_req.req = 1'b0;
        @(negedge clk);
        chk("idle_sram_cs", {31'd0, sram_cs}, 32'd0);
        @(posedge clk); #1;

        // Read, then address aliasing of ignored bits.
        preload(13'h010, 32'hDEAD_BEEF);
        obi_txn(1'b0, 4'hF, 32'h0000_0040, 32'd0, 32'hDEAD_BEEF, 1, "read", w);
        chk("read_wait", w, 0);
        obi_txn(1'b0, 4'hF, 32'hFFF0_8041, 32'd0, 32'hDEAD_BEEF, 1, "alias", w);

        // Full write and readback.
        obi_txn(1'b1, 4'hF, 32'h0000_0044, 32'h1234_5678, 32'd0, 1, "fullwr", w);
        chk("fullwr_mem", mem[13'h011], 32'h1234_5678);
        obi_txn(1'b0, 4'hF, 32'h0000_0044, 32'd0, 32'h1234_5678, 1, "fullrd", w);

        // be=0: acknowledged but no SRAM access.
        preload(13'h012, 32'hCAFE_F00D);
        a0 = acc_cnt;
        obi_txn(1'b1, 4'h0, 32'h0000_0048, 32'hFFFF_FFFF, 32'd0, 1, "be0", w);
        chk("be0_access", acc_cnt - a0, 0);
        chk("be0_mem", mem[13'h012], 32'hCAFE_F00D);

        // Partial write via read-modify-write.
        preload(13'h013, 32'hAABB_CCDD);
        obi_txn(1'b1, 4'b0101, 32'h0000_004C, 32'h1122_3344, 32'd0, 3, "partial", w);
        chk("partial_mem", mem[13'h013], 32'hAA22_CC44);

        // Core priority: core busy for 5 cycles while a read waits.
        fork
            obi_txn(1'b0, 4'hF, 32'h0000_0044, 32'd0, 32'h1234_5678, 1, "prio", w);
            begin
                core_cs = 1'b1; core_we = 1'b0; core_addr = 13'h010;
                repeat (5) @(posedge clk);
                #1 core_cs = 1'b0;
            end
        join
        chk("prio_wait", w, 5);
`ifdef TINYODIN_SYN_BRIDGE_STATS_EN
        chk("stall_cnt", stall_cnt, 32'd5);
`endif

        // Hazard: core writes the latched word during RMW_WR, forcing a re-read.
        preload(13'h020, 32'h1234_5678);
        fork
            obi_txn(1'b1, 4'b0001, 32'h0000_0080, 32'h0000_00AB, 32'd0, 6, "hazard", w);
            begin
                repeat (2) @(posedge clk);
                #1 core_cs = 1'b1; core_we = 1'b1; core_addr = 13'h020; core_wdata = 32'hFFFF_0000;
                @(posedge clk);
                #1 core_cs = 1'b0; core_we = 1'b0;
            end
        join
        chk("hazard_mem", mem[13'h020], 32'hFFFF_00AB);

        // Core write elsewhere during RMW_WR only delays the write.
        preload(13'h021, 32'h0011_2233);
        fork
            obi_txn(1'b1, 4'b1000, 32'h0000_0084, 32'hAA00_0000, 32'd0, 4, "nohaz", w);
            begin
                repeat (2) @(posedge clk);
                #1 core_cs = 1'b1; core_we = 1'b1; core_addr = 13'h030; core_wdata = 32'h0000_0055;
                @(posedge clk);
                #1 core_cs = 1'b0; core_we = 1'b0;
            end
        join
        chk("nohaz_mem", mem[13'h021], 32'hAA11_2233);
        chk("nohaz_core_mem", mem[13'h030], 32'h0000_0055);

        // Reset during RMW_RD abandons the sequence.
        preload(13'h022, 32'h0102_0304);
        w0 = wr_cnt;
        obi_req = '{req: 1'b1, we: 1'b1, be: 4'b0011, addr: 32'h0000_0088, wdata: 32'hFFFF_FFFF};
        @(negedge clk);
        chk("rst_rmw_gnt", {31'd0, obi_resp.gnt}, 32'd1);
        @(posedge clk); #1;
        obi_req.req = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_rmw_rvalid", {31'd0, obi_resp.rvalid}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", {31'd0, obi_resp.rvalid}, 32'd0);
        end
        @(posedge clk); #1;
        chk("rst_rmw_writes", wr_cnt - w0, 0);
        chk("rst_rmw_mem", mem[13'h022], 32'h0102_0304);
        obi_txn(1'b0, 4'hF, 32'h0000_0088, 32'd0, 32'h0102_0304, 1, "post_rst_read", w);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinyodin_synapse_obi_bridge.md
Name: tinyodin_synapse_obi_bridge

Overview:
OBI slave that sits directly downstream of the tinyODIN address decoder on the synapsecore branch (addr[21:20]=2'b10). It shares the single-port synaptic SRAM between the SNN core and the host bus, with strict core priority. It converts OBI byte-enabled writes into read-modify-write sequences, because the SRAM has no byte enables. It returns read data and write acknowledgements with OBI rvalid timing.

Parameters:
req_t, logic, OBI request struct type (obi_pkg).
rsp_t, logic, OBI response struct type (obi_pkg).
SYN_AW, 13, synaptic SRAM word-address width (2^13 x 32 b = 32 KiB).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
obi_req_i  in  req_t  OBI request (req, we, be, addr, wdata)
obi_resp_o  out  rsp_t  OBI response (gnt, rvalid, rdata)
core_syn_cs_i  in  1  core SRAM access request
core_syn_we_i  in  1  core write enable
core_syn_addr_i  in  SYN_AW  core word address
core_syn_wdata_i  in  32  core write data
core_syn_rdata_o  out  32  core read data (direct from sram_rdata_i)
sram_cs_o  out  1  SRAM chip select
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  SYN_AW  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data, valid 1 cycle after read cs
stall_cnt_o  out  32  bus stall counter (only present with TINYODIN_SYN_BRIDGE_STATS_EN)

Behaviour:
- Word address = obi addr[SYN_AW+1:2]. addr[1:0] and bits above SYN_AW+1 are ignored.
- SRAM port mux: when core_syn_cs_i=1 the core drives the SRAM unconditionally in that cycle, and the bridge issues nothing.
- gnt = obi req & state==IDLE & !core_syn_cs_i & !rst_i. gnt is combinational and is never asserted outside IDLE.
- Read granted in cycle N: SRAM read issued in N; rvalid=1 and rdata=sram_rdata_i in N+1.
- Write with be=4'hF granted in N: SRAM write in N; rvalid=1 and rdata=0 in N+1.
- Write with be=4'h0: acknowledged like a full write, but no SRAM access is issued.
- Partial write (other be values): address, be and wdata are latched at gnt, then the FSM runs:
  - IDLE -> RMW_RD: read issued in the grant cycle, or in the first cycle without core_syn_cs_i.
  - RMW_RD -> RMW_WR: the next cycle captures sram_rdata_i into a merge register. Merged word: byte i = be[i] ? wdata byte : old byte.
  - RMW_WR: write is issued when the core is idle, then the FSM goes to RESP.
  - RESP: rvalid=1, rdata=0, then IDLE.
- Hazard: a core write to the latched address while in RMW_WR aborts the merge and returns to RMW_RD (re-read). Core reads cause no re-read.
- Only one OBI transaction is outstanding at a time. For a read or full write, a new gnt is allowed in the same cycle as the previous rvalid.
- Reset values: rvalid=0, rdata=0, FSM=IDLE, merge/latch registers=0, stall counter=0. The SRAM outputs follow the core inputs.
- A reset during RMW abandons the sequence; no SRAM write is issued and no rvalid is produced.

Optional Feature:
TINYODIN_SYN_BRIDGE_STATS_EN
- Defined: stall_cnt_o is present. It increments each cycle in which obi req=1 and gnt=0, saturates at 32'hFFFFFFFF, and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tinyodin_syn_bridge_pkg: state enum (IDLE, RMW_RD, RMW_WR, RESP), SYN_WORD_W=32, SYN_BE_W=4.
- Sub-module tinyodin_be_merge: purely combinational byte merge (old word, new word, be -> merged word).

Test Plan:
- Read: preload word 0x10 with 0xDEADBEEF; OBI read addr 0x40 -> gnt in N, rvalid in N+1, rdata=0xDEADBEEF.
- Full write: write 0x12345678 to addr 0x44, be=F -> rvalid in N+1, rdata=0; a following read returns 0x12345678.
- Partial write: word=0xAABBCCDD; write wdata=0x11223344, be=4'b0101 -> SRAM holds 0xAA22CC44; rvalid 3 cycles after gnt when the core is idle.
- Core priority: hold core_syn_cs_i high 5 cycles while an OBI read is pending -> gnt=0 for all 5 cycles; gnt in the 6th cycle; stall_cnt_o=5 when the stats feature is enabled.
- Hazard: partial write be=4'b0001 to word 0x20; core writes 0xFFFF0000 to 0x20 during RMW_WR -> re-read occurs; final value is 0xFFFF00xx with the OBI byte.
- Reset mid-RMW: assert rst_i in RMW_RD -> no SRAM write, rvalid=0, FSM=IDLE; the next OBI read is served normally.
